// File: rtl/roic_line_packer_if.sv
// Output stream bundle of the TI-ROIC line packer.
//   m_tdata   {B,A} packed channel pair
//   m_tvalid  stream valid (driven by the packer)
//   m_tready  stream ready (driven by the consumer)
//   m_tlast   last pair of a line
//   m_tuser   first pair of a frame
interface roic_line_packer_if #(
  parameter int DATA_WIDTH = 24
);
  logic [2*DATA_WIDTH-1:0] m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;
  logic                    m_tlast;
  logic                    m_tuser;

  modport master (
    output m_tdata,
    output m_tvalid,
    output m_tlast,
    output m_tuser,
    input  m_tready
  );

  modport slave (
    input  m_tdata,
    input  m_tvalid,
    input  m_tlast,
    input  m_tuser,
    output m_tready
  );
endinterface

// File: rtl/roic_line_packer.sv
// roic_line_packer: frames reordered A/B channel pairs into lines, buffers
// them in a small first-word-fall-through FIFO and presents them as a
// valid/ready stream tagged with start-of-frame (tuser) and end-of-line
// (tlast). Flags short lines, surplus pairs after a complete line, and
// pairs lost to a full FIFO.
//
// Ports
//   clk            data-read clock, sole clock
//   rst_n          asynchronous active-low reset
//   frame_start    1-cycle pulse, new frame begins
//   sync           1-cycle pulse, new line begins
//   in_valid       A/B pair valid this cycle
//   in_data_a/b    channel A / channel B words
//   m_axis         output stream (master side of roic_line_packer_if)
//   line_cnt       completed lines since frame_start (wraps)
//   short_line_err 1-cycle pulse: line ended before PAIRS_PER_LINE pairs
//   long_line_err  1-cycle pulse: pair after a complete line dropped
//   overflow       sticky: pair dropped on FIFO full, cleared by frame_start
module roic_line_packer #(
  parameter int DATA_WIDTH     = 24,
  parameter int PAIRS_PER_LINE = 128,
  parameter int FIFO_DEPTH     = 16,
  parameter int LINE_CNT_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  sync,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data_a,
  input  logic [DATA_WIDTH-1:0] in_data_b,
  roic_line_packer_if.master    m_axis,
  output logic [LINE_CNT_W-1:0] line_cnt,
  output logic                  short_line_err,
  output logic                  long_line_err,
  output logic                  overflow
);

  localparam int unsigned PCW = $clog2(PAIRS_PER_LINE);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned EW  = 2 * DATA_WIDTH + 2;   // {B, A, tlast, tuser}
  localparam logic [PCW-1:0] LAST_IDX = PCW'(PAIRS_PER_LINE - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_LINE = 2'd1;
  localparam logic [1:0] S_ACTIVE    = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PCW-1:0]        pair_cnt_q, pair_cnt_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic                  sof_q, sof_d;
  logic                  line_done_q, line_done_d;
  logic                  short_q, short_d;
  logic                  long_q, long_d;
  logic                  ovf_q, ovf_d;
  logic                  stg_vld_q, stg_vld_d;
  logic [EW-1:0]         stg_ent_q, stg_ent_d;

  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic                  empty, full, push, pop, drop;
  logic [EW-1:0]         head;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && m_axis.m_tready;
  // A pop in the same cycle frees the slot the staged pair needs.
  assign push  = stg_vld_q && (!full || pop);
  assign drop  = stg_vld_q && full && !pop;

  // Framing: frame_start is applied first, then sync, then the incoming pair,
  // so simultaneous events resolve by sequential overrides of the _d values.
  always_comb begin
    state_d     = state_q;
    pair_cnt_d  = pair_cnt_q;
    line_cnt_d  = line_cnt_q;
    sof_d       = sof_q;
    line_done_d = line_done_q;
    short_d     = 1'b0;
    long_d      = 1'b0;
    stg_vld_d   = 1'b0;
    stg_ent_d   = stg_ent_q;

    if (frame_start) begin
      state_d     = S_WAIT_LINE;
      line_cnt_d  = '0;
      sof_d       = 1'b1;
      line_done_d = 1'b0;
    end

    if (sync) begin
      if (state_d == S_WAIT_LINE) begin
        state_d     = S_ACTIVE;
        pair_cnt_d  = '0;
        line_done_d = 1'b0;
      end else if (state_d == S_ACTIVE) begin
        short_d    = 1'b1;
        pair_cnt_d = '0;
      end
    end

    if (in_valid && !frame_start) begin
      if (state_d == S_ACTIVE) begin
        stg_vld_d = 1'b1;
        stg_ent_d = {in_data_b, in_data_a, (pair_cnt_d == LAST_IDX), sof_d};
        sof_d     = 1'b0;
        if (pair_cnt_d == LAST_IDX) begin
          pair_cnt_d  = '0;
          line_cnt_d  = line_cnt_d + LINE_CNT_W'(1);
          line_done_d = 1'b1;
          state_d     = S_WAIT_LINE;
        end else begin
          pair_cnt_d = pair_cnt_d + PCW'(1);
        end
      end else if (state_d == S_WAIT_LINE && line_done_d) begin
        long_d = 1'b1;
      end
    end

    ovf_d = frame_start ? 1'b0 : (ovf_q || drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pair_cnt_q  <= '0;
      line_cnt_q  <= '0;
      sof_q       <= 1'b0;
      line_done_q <= 1'b0;
      short_q     <= 1'b0;
      long_q      <= 1'b0;
      ovf_q       <= 1'b0;
      stg_vld_q   <= 1'b0;
      stg_ent_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      pair_cnt_q  <= pair_cnt_d;
      line_cnt_q  <= line_cnt_d;
      sof_q       <= sof_d;
      line_done_q <= line_done_d;
      short_q     <= short_d;
      long_q      <= long_d;
      ovf_q       <= ovf_d;
      stg_vld_q   <= stg_vld_d;
      stg_ent_q   <= stg_ent_d;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= stg_ent_q;
  end

  // Head is forced to zero while empty so the stream reads 0 out of reset.
  assign head            = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign m_axis.m_tvalid = !empty;
  assign m_axis.m_tdata  = head[EW-1:2];
  assign m_axis.m_tlast  = head[1];
  assign m_axis.m_tuser  = head[0];

  assign line_cnt       = line_cnt_q;
  assign short_line_err = short_q;
  assign long_line_err  = long_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_roic_line_packer.sv
module tb_roic_line_packer;
  localparam int DW  = 24;
  localparam int PPL = 128;
  localparam int FD  = 16;
  localparam int LCW = 12;

  typedef logic [2*DW+1:0] ent_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           frame_start = 1'b0;
  logic           sync = 1'b0;
  logic           in_valid = 1'b0;
  logic [DW-1:0]  a = '0;
  logic [DW-1:0]  b = '0;
  logic [LCW-1:0] line_cnt;
  logic           short_line_err, long_line_err, overflow;

  roic_line_packer_if #(.DATA_WIDTH(DW)) bus ();

  roic_line_packer #(
    .DATA_WIDTH(DW), .PAIRS_PER_LINE(PPL), .FIFO_DEPTH(FD), .LINE_CNT_W(LCW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .sync(sync),
    .in_valid(in_valid), .in_data_a(a), .in_data_b(b), .m_axis(bus),
    .line_cnt(line_cnt), .short_line_err(short_line_err),
    .long_line_err(long_line_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  ent_t exp_q[$];
  int nvec = 0, nerr = 0;
  int beats = 0, lasts = 0, users = 0, shorts = 0, longs = 0;
  logic rnd_mode = 1'b0, rnd_bit = 1'b0, tready_force = 1'b1;
  logic prev_stall = 1'b0;
  ent_t prev_ent = '0;

  assign bus.m_tready = rnd_mode ? rnd_bit : tready_force;

  always @(posedge clk) begin
    #1;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: scoreboard pop on every handshake, hold check while stalled.
  always @(negedge clk) begin
    ent_t cur, e;
    cur = {bus.m_tdata, bus.m_tlast, bus.m_tuser};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        nvec++;
        if (!bus.m_tvalid || cur !== prev_ent) begin
          nerr++;
          $display("FAIL hold: got valid=%0b ent=%h want valid=1 ent=%h",
                   bus.m_tvalid, cur, prev_ent);
        end
      end
      if (short_line_err) shorts++;
      if (long_line_err)  longs++;
      if (bus.m_tvalid && bus.m_tready) begin
        beats++;
        if (bus.m_tlast) lasts++;
        if (bus.m_tuser) users++;
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL beat: got unexpected ent=%h want no beat", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            nerr++;
            $display("FAIL beat%0d: got %h want %h", beats - 1, cur, e);
          end
        end
      end
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_ent   = cur;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic fs, input logic sy, input logic iv,
                      input int av, input int bv);
    frame_start = fs;
    sync        = sy;
    in_valid    = iv;
    a           = DW'(av);
    b           = DW'(bv);
    @(posedge clk);
    #1;
    frame_start = 1'b0;
    sync        = 1'b0;
    in_valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic pair(input logic sy, input int i, input bit expect_out,
                      input bit last, input bit user);
    if (expect_out) exp_q.push_back({DW'(i + 1000), DW'(i), last, user});
    step(1'b0, sy, 1'b1, i, i + 1000);
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s drain: got %0d pending want 0", nm, exp_q.size());
      exp_q.delete();
    end
    idle(3);
  endtask

  task automatic reset_counts();
    beats = 0; lasts = 0; users = 0; shorts = 0; longs = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("rst_tvalid", bus.m_tvalid, 0);
    check("rst_tdata", bus.m_tdata, 0);
    check("rst_tags", {bus.m_tlast, bus.m_tuser}, 0);
    check("rst_line_cnt", line_cnt, 0);
    check("rst_flags", {short_line_err, long_line_err, overflow}, 0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: one complete line
    reset_counts();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < PPL; i++) pair(1'b0, i, 1'b1, i == PPL - 1, i == 0);
    wait_drain("t1");
    check("t1_beats", beats, 128);
    check("t1_tlast", lasts, 1);
    check("t1_tuser", users, 1);
    check("t1_line_cnt", line_cnt, 1);
    check("t1_short", shorts, 0);

    // 2: short line of 50, then sync coincident with pair 0 of a full line
    reset_counts();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 50; i++) pair(1'b0, i, 1'b1, 1'b0, i == 0);
    for (int i = 0; i < PPL; i++) pair(i == 0, i, 1'b1, i == PPL - 1, 1'b0);
    wait_drain("t2");
    check("t2_short", shorts, 1);
    check("t2_beats", beats, 178);
    check("t2_tlast", lasts, 1);
    check("t2_tuser", users, 1);
    check("t2_line_cnt", line_cnt, 1);

    // 3: stall output through 40 pairs: 16 stored, 24 dropped
    reset_counts();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    tready_force = 1'b0;
    for (int i = 0; i < 40; i++) pair(1'b0, i, i < FD, 1'b0, i == 0);
    idle(3);
    check("t3_overflow_set", overflow, 1);
    check("t3_tvalid_full", bus.m_tvalid, 1);
    tready_force = 1'b1;
    wait_drain("t3a");
    for (int i = 40; i < PPL; i++) pair(1'b0, i, 1'b1, i == PPL - 1, 1'b0);
    wait_drain("t3b");
    check("t3_beats", beats, 104);
    check("t3_tlast", lasts, 1);
    check("t3_overflow_sticky", overflow, 1);
    check("t3_line_cnt", line_cnt, 1);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    check("t3_overflow_clr", overflow, 0);
    check("t3_line_cnt_clr", line_cnt, 0);

    // 4: complete line then 3 surplus pairs before the next sync
    reset_counts();
    step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < PPL; i++) pair(1'b0, i, 1'b1, i == PPL - 1, i == 0);
    for (int k = 0; k < 3; k++) pair(1'b0, 200 + k, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("t4_long", longs, 3);
    wait_drain("t4");
    check("t4_beats", beats, 128);
    check("t4_line_cnt", line_cnt, 1);

    // 5: asynchronous reset with pairs queued
    reset_counts();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    tready_force = 1'b0;
    for (int i = 0; i < 5; i++) pair(1'b0, i, 1'b0, 1'b0, 1'b0);
    idle(3);
    check("t5_tvalid_queued", bus.m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", bus.m_tvalid, 0);
    check("t5_rst_tdata", bus.m_tdata, 0);
    check("t5_rst_tags", {bus.m_tlast, bus.m_tuser}, 0);
    check("t5_rst_flags", {short_line_err, long_line_err, overflow}, 0);
    check("t5_rst_line_cnt", line_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tready_force = 1'b1;
    pair(1'b1, 300, 1'b0, 1'b0, 1'b0);
    pair(1'b0, 301, 1'b0, 1'b0, 1'b0);
    pair(1'b0, 302, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("t5_ignored_beats", beats, 0);
    step(1'b1, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) pair(1'b0, 400 + i, 1'b1, 1'b0, i == 0);
    wait_drain("t5");
    check("t5_beats", beats, 4);
    check("t5_tuser", users, 1);

    // 6: four lines with random backpressure, paced to avoid overflow
    reset_counts();
    step(1'b1, 1'b0, 1'b0, 0, 0);
    rnd_mode = 1'b1;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < PPL; i++) begin
        int k;
        k = 0;
        while (exp_q.size() >= 12 && k < 200) begin
          idle(1);
          k++;
        end
        if (k >= 200) begin
          nvec++;
          nerr++;
          $display("FAIL t6_pace: got %0d pending want <12", exp_q.size());
        end
        pair(i == 0, l * PPL + i, 1'b1, i == PPL - 1, l == 0 && i == 0);
      end
    end
    wait_drain("t6");
    rnd_mode = 1'b0;
    check("t6_beats", beats, 512);
    check("t6_tlast", lasts, 4);
    check("t6_tuser", users, 1);
    check("t6_line_cnt", line_cnt, 4);
    check("t6_overflow", overflow, 0);
    check("t6_errs", shorts + longs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
